sort4_ctrl: RTL and testbench

Sequencer that sorts a small register file of unsigned 4-bit values into ascending order, using one shared 4-bit greater-than comparator (a > b, strict).
- Runs bubble-sort passes as compare/swap micro-steps, one comparator evaluation per cycle, and exits early when a pass makes no swap.
- Sits between a host that loads and reads values and the comparator datapath; the host sees a start/ready/done handshake.

---
 rtl/sort_pkg.sv | 23 ++
 rtl/gt_4.sv | 10 +
 rtl/sort4_ctrl.sv | 119 +++++++++++
 tb/tb_sort4_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared sizing, state encoding and helpers for the 4-entry bubble-sort sequencer.
package sort_pkg;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMP  = 2'b01,
        SWAP = 2'b10,
        DONE = 2'b11
    } state_e;

    // Never wraps: the counter is sized so a legal sort cannot reach its maximum.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

endpackage

// File: rtl/gt_4.sv
// Shared 4-bit strict greater-than comparator: y = (a > b), unsigned.
module gt_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       y
);

    assign y = (a > b);

endmodule

// File: rtl/sort4_ctrl.sv
// Bubble-sort sequencer over a 4-entry register file, one compare per cycle,
// early exit on a swap-free pass; host sees start/ready/done_tick.
module sort4_ctrl
    import sort_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [W-1:0]  load_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          ready,
    output logic          done_tick,
    output logic [CW-1:0] swap_cnt
);

    state_e        state_q;
    logic [W-1:0]  mem_q [N];
    logic [AW-1:0] idx_q;
    logic [AW-1:0] pass_q;
    logic          swapped_q;
    logic          done_q;
    logic          ready_q;
    logic [CW-1:0] swap_cnt_q;

    logic [AW-1:0] idx_d;
    logic [AW-1:0] pass_d;
    logic [CW-1:0] swap_cnt_d;
    logic          gt;
    logic          last_cmp;
    logic          last_pass;

    assign idx_d      = idx_q + AW'(1);
    assign pass_d     = pass_q + AW'(1);
    assign swap_cnt_d = sat_inc(swap_cnt_q);
    assign last_cmp   = (idx_q == (LAST_IDX - pass_q));
    assign last_pass  = (pass_q == LAST_IDX);

    gt_4 u_gt (
        .a (mem_q[idx_q]),
        .b (mem_q[idx_d]),
        .y (gt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            swapped_q  <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            swap_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) mem_q[load_addr] <= load_data;
                    if (start) begin
                        swap_cnt_q <= '0;
                        pass_q     <= '0;
                        idx_q      <= '0;
                        swapped_q  <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    if (gt) begin
                        state_q <= SWAP;
                    end else if (!last_cmp) begin
                        idx_q <= idx_d;
                    end else if (!swapped_q || last_pass) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        pass_q    <= pass_d;
                        idx_q     <= '0;
                        swapped_q <= 1'b0;
                    end
                end
                SWAP: begin
                    mem_q[idx_q] <= mem_q[idx_d];
                    mem_q[idx_d] <= mem_q[idx_q];
                    swap_cnt_q   <= swap_cnt_d;
                    // This pass just swapped, so only the pass limit can end the sort here.
                    if (!last_cmp) begin
                        swapped_q <= 1'b1;
                        idx_q     <= idx_d;
                        state_q   <= CMP;
                    end else if (last_pass) begin
                        swapped_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        swapped_q <= 1'b0;
                        pass_q    <= pass_d;
                        idx_q     <= '0;
                        state_q   <= CMP;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data   = mem_q[rd_addr];
    assign ready     = ready_q;
    assign done_tick = done_q;
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: directed cases plus random arrays
// compared against a plain bubble-sort model with early exit.
module tb_sort4_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [3:0] load_data = '0;
    logic [1:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       ready;
    logic       done_tick;
    logic [2:0] swap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int vin   [4];
    int exp_v [4];
    int exp_cyc;
    int exp_swp;
    int edges;
    int dones;

    sort4_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ready     (ready),
        .done_tick (done_tick),
        .swap_cnt  (swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bubble sort with early exit; one cycle per compare and one per swap.
    task automatic model();
        int v[4];
        bit any;
        v = vin;
        exp_cyc = 0;
        exp_swp = 0;
        for (int p = 0; p <= 2; p++) begin
            any = 1'b0;
            for (int i = 0; i <= 2 - p; i++) begin
                exp_cyc++;
                if (v[i] > v[i+1]) begin
                    int t;
                    t = v[i]; v[i] = v[i+1]; v[i+1] = t;
                    exp_swp++;
                    exp_cyc++;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
        exp_v = v;
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = 2'(i);
            load_data = 4'(vin[i]);
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic check_mem(input string tag, input bit zero);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check($sformatf("%s_mem%0d", tag, i), int'(rd_data), zero ? 0 : exp_v[i]);
        end
    endtask

    // Starts a sort (edge k) and counts edges until done_tick; optionally pokes
    // load/start while busy during cycle k+3.
    task automatic run_sort(input string tag, input bit inject);
        model();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, int'(ready), 0);
        edges = 0;
        dones = 0;
        do begin
            if (inject && edges == 2) begin
                load_en = 1'b1; load_addr = 2'd0; load_data = 4'd0; start = 1'b1;
            end
            step();
            load_en = 1'b0;
            start   = 1'b0;
            edges++;
        end while (!done_tick && edges < 100);
        check({tag, "_latency"}, edges, exp_cyc);
        check({tag, "_ready_at_done"}, int'(ready), 0);
        if (done_tick) dones++;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done_tick) dones++;
        end
        check({tag, "_one_done"}, dones, 1);
        check({tag, "_ready_after"}, int'(ready), 1);
        check({tag, "_swaps"}, int'(swap_cnt), exp_swp);
        check_mem(tag, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_ready_low", int'(ready), 1);
        check("rst_done_low", int'(done_tick), 0);
        reset_n = 1'b1;
        step();
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done_tick), 0);
        check("rst_swaps", int'(swap_cnt), 0);
        check_mem("rst", 1'b1);

        vin = '{0, 1, 2, 3};
        load_all();
        run_sort("sorted", 1'b0);
        check("sorted_cyc4", edges + 1, 4);

        vin = '{9, 3, 12, 3};
        load_all();
        run_sort("mixed", 1'b0);
        check("mixed_cyc10", edges + 1, 10);

        vin = '{15, 14, 13, 12};
        load_all();
        run_sort("reversed", 1'b0);
        check("reversed_cyc13", edges + 1, 13);

        vin = '{15, 14, 13, 12};
        load_all();
        run_sort("busy_ignore", 1'b1);

        // Same-cycle load and start: the sort must see the freshly loaded value.
        vin = '{4, 5, 6, 7};
        load_all();
        vin = '{8, 5, 6, 7};
        load_en = 1'b1; load_addr = 2'd0; load_data = 4'd8;
        run_sort("load_start", 1'b0);

        vin = '{15, 14, 13, 12};
        load_all();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        reset_n = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_done", int'(done_tick), 0);
        check("abort_swaps", int'(swap_cnt), 0);
        check_mem("abort", 1'b1);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done_tick) dones++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done_tick) dones++;
        end
        check("abort_no_done", dones, 0);
        vin = '{5, 2, 7, 1};
        load_all();
        run_sort("after_abort", 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++)
                vin[i] = (r % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            load_all();
            run_sort($sformatf("rand%0d", r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
